// File: rtl/prf_arb_pkg.sv
// Shared types and defaults for the predicate register file write arbiter.
//   arb_state_e : arbiter mode, IDLE (round-robin) or LOCKED (one owner holds the port)
//   DEF_*       : default parameter values used by the top level
//   id_width()  : width of a requester id for a given requester count (at least 1)
package prf_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDXW  = 5;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prf_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority requester; the scan runs ptr, ptr+1, ... wrapping
//   grant : one-hot winner (all zero when nothing is requested)
//   id    : winner index (0 when nothing is requested)
//   any   : at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        cand  = '0;
        // NREQ is a power of two, so the IDW-bit add wraps modulo NREQ.
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + IDW'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                id  = cand;
            end
        end
        if (any) begin
            grant[id] = 1'b1;
        end
    end

endmodule

// File: rtl/prf_write_arbiter.sv
// Round-robin write arbiter for the predicate register file write port.
// NREQ producers offer val/rdy beats; one winner per cycle is registered into
// a single-entry output stage that drives the register-file write port.
// A producer may lock the port across a multi-beat burst.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_val    : per-requester beat valid
//   req_rdy    : per-requester beat accepted this cycle (at most one bit set)
//   req_lock   : per-requester keep-grant request, sampled on an accepted beat
//   req_msg    : flattened beat data, slice i = [i*WIDTH +: WIDTH]
//   req_idx    : flattened register index, slice i = [i*IDXW +: IDXW]
//   wr_msg     : registered write data
//   wr_idx     : registered write index
//   wr_src     : requester id of the held beat
//   wr_val     : output stage holds a beat
//   wr_rdy     : register file takes the held beat
module prf_write_arbiter
    import prf_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDXW  = DEF_IDXW,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*WIDTH-1:0] req_msg,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [WIDTH-1:0]     wr_msg,
    output logic [IDXW-1:0]      wr_idx,
    output logic [IDW-1:0]       wr_src,
    output logic                 wr_val,
    input  logic                 wr_rdy
);

    arb_state_e     state, state_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;

    logic            adv;
    logic            accept;
    logic [IDW-1:0]  sel;
    logic [WIDTH-1:0] sel_msg;
    logic [IDXW-1:0] sel_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_val),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    // The output stage can take a new beat when empty or draining this cycle.
    assign adv = !wr_val || wr_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        req_rdy    = '0;
        // req_rdy is gated by rst_n so nothing is granted while reset is held.
        if (rst_n && adv) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        req_rdy = pick_grant;
                        if (req_lock[pick_id]) begin
                            state_nxt = LOCKED;
                            owner_nxt = pick_id;
                        end else begin
                            rr_ptr_nxt = pick_id + IDW'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Only the owner is eligible, even while it has nothing to send.
                    if (req_val[owner]) begin
                        req_rdy[owner] = 1'b1;
                        if (!req_lock[owner]) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = owner + IDW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign accept = |req_rdy;
    assign sel    = (state == LOCKED) ? owner : pick_id;

    always_comb begin
        sel_msg = '0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                sel_msg = req_msg[i*WIDTH +: WIDTH];
                sel_idx = req_idx[i*IDXW +: IDXW];
            end
        end
    end

    // Output stage: replaced without a bubble when a held beat drains and a
    // new one is accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_val <= 1'b0;
            wr_msg <= '0;
            wr_idx <= '0;
            wr_src <= '0;
        end else if (accept) begin
            wr_val <= 1'b1;
            wr_msg <= sel_msg;
            wr_idx <= sel_idx;
            wr_src <= sel;
        end else if (wr_rdy) begin
            wr_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prf_write_arbiter.sv
module tb_prf_write_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDXW  = 5;
    localparam int IDW   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_val;
    logic [NREQ-1:0]        req_rdy;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*WIDTH-1:0]  req_msg;
    logic [NREQ*IDXW-1:0]   req_idx;
    logic [WIDTH-1:0]       wr_msg;
    logic [IDXW-1:0]        wr_idx;
    logic [IDW-1:0]         wr_src;
    logic                   wr_val;
    logic                   wr_rdy;

    prf_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDXW  (IDXW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_lock (req_lock),
        .req_msg  (req_msg),
        .req_idx  (req_idx),
        .wr_msg   (wr_msg),
        .wr_idx   (wr_idx),
        .wr_src   (wr_src),
        .wr_val   (wr_val),
        .wr_rdy   (wr_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [4:0]  idx;
        logic [31:0] msg;
    } beat_t;

    beat_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: arbitration rules at the behavioural level.
    int m_ptr    = 0;
    bit m_locked = 0;
    int m_owner  = 0;
    bit m_held   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 0;
        m_owner  = 0;
        m_held   = 0;
        q.delete();
    endtask

    // Called at a falling edge: drive inputs, check req_rdy against the model,
    // record the accepted beat and advance the model to the next rising edge.
    task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                               input logic r, output logic [NREQ-1:0] got);
        logic [NREQ-1:0] exp_rdy;
        int   win;
        bit   adv;
        beat_t b;
        req_val  = v;
        req_lock = l;
        wr_rdy   = r;
        for (int i = 0; i < NREQ; i++) begin
            req_msg[i*WIDTH +: WIDTH] = $urandom;
            req_idx[i*IDXW +: IDXW]   = IDXW'($urandom_range(0, 31));
        end
        #2;
        got     = req_rdy;
        exp_rdy = '0;
        win     = -1;
        if (rst_n) begin
            adv = !m_held || r;
            if (adv) begin
                if (!m_locked) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int i;
                        i = (m_ptr + k) % NREQ;
                        if (win < 0 && v[i]) win = i;
                    end
                end else if (v[m_owner]) begin
                    win = m_owner;
                end
            end
            if (win >= 0) begin
                exp_rdy[win] = 1'b1;
                b.src = win;
                b.idx = req_idx[win*IDXW +: IDXW];
                b.msg = req_msg[win*WIDTH +: WIDTH];
                q.push_back(b);
                if (!m_locked) begin
                    if (l[win]) begin
                        m_locked = 1;
                        m_owner  = win;
                    end else begin
                        m_ptr = (win + 1) % NREQ;
                    end
                end else if (!l[win]) begin
                    m_locked = 0;
                    m_ptr    = (win + 1) % NREQ;
                end
                m_held = 1;
            end else if (r) begin
                m_held = 0;
            end
        end
        chk("req_rdy", longint'(got), longint'(exp_rdy));
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                        input logic r, output logic [NREQ-1:0] got);
        @(negedge clk);
        drive_cycle(v, l, r, got);
    endtask

    // Monitor: the expected beat queue decides wr_val; each output handshake
    // pops one beat and compares it.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("wr_val", longint'(wr_val), longint'(q.size() != 0));
                if (wr_val && wr_rdy && q.size() != 0) begin
                    e = q.pop_front();
                    chk("wr_src", longint'(wr_src), longint'(e.src));
                    chk("wr_idx", longint'(wr_idx), longint'(e.idx));
                    chk("wr_msg", longint'(wr_msg), longint'(e.msg));
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] got;
        logic [NREQ-1:0] rv, rl;
        rst_n    = 1'b0;
        req_val  = '1;
        req_lock = '0;
        req_msg  = '0;
        req_idx  = '0;
        wr_rdy   = 1'b1;
        model_reset();

        // Reset held with every requester active.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_rdy", longint'(req_rdy), 0);
        chk("rst_wr_val",  longint'(wr_val),  0);
        chk("rst_wr_msg",  longint'(wr_msg),  0);
        chk("rst_wr_idx",  longint'(wr_idx),  0);
        chk("rst_wr_src",  longint'(wr_src),  0);

        // Release: requester 0 wins on the first edge, then strict rotation.
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b1111, 4'b0000, 1'b1, got);
        chk("first_grant", longint'(got), 1);
        for (int k = 1; k < 8; k++) begin
            step(4'b1111, 4'b0000, 1'b1, got);
            chk("fair_order", longint'(got), longint'(1 << (k % 4)));
        end

        // Backpressure: held beat stays, nothing granted, pointer frozen.
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 4'b0000, 1'b0, got);
            chk("bp_no_grant", longint'(got), 0);
        end
        step(4'b1111, 4'b0000, 1'b1, got);
        chk("bp_resume", longint'(got), 1);

        // Locked burst from requester 2, then round-robin moves to 3.
        step(4'b0100, 4'b0100, 1'b1, got);
        chk("lock_beat0", longint'(got), 4);
        step(4'b1111, 4'b0100, 1'b1, got);
        chk("lock_beat1", longint'(got), 4);
        step(4'b1111, 4'b0000, 1'b1, got);
        chk("lock_beat2", longint'(got), 4);
        step(4'b1111, 4'b0000, 1'b1, got);
        chk("after_lock", longint'(got), 8);

        // Locked owner 1 goes idle: others are shut out.
        step(4'b0010, 4'b0010, 1'b1, got);
        chk("own1_lock", longint'(got), 2);
        step(4'b1101, 4'b0000, 1'b1, got);
        chk("own_idle0", longint'(got), 0);
        step(4'b1101, 4'b0000, 1'b1, got);
        chk("own_idle1", longint'(got), 0);
        step(4'b1111, 4'b0010, 1'b1, got);
        chk("own_resume", longint'(got), 2);
        step(4'b1111, 4'b0010, 1'b0, got);
        chk("own_stall", longint'(got), 0);

        // Reset mid-burst with a beat held.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_wr_val", longint'(wr_val), 0);
        chk("midrst_wr_src", longint'(wr_src), 0);
        chk("midrst_rdy",    longint'(req_rdy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b1111, 4'b0000, 1'b1, got);
        chk("midrst_restart", longint'(got), 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rv = NREQ'($urandom);
            rl = '0;
            for (int i = 0; i < NREQ; i++) rl[i] = ($urandom_range(0, 3) == 0);
            step(rv, rl, ($urandom_range(0, 3) != 0), got);
        end

        // Drain: release any lock and empty the output stage.
        step(4'b1111, 4'b0000, 1'b1, got);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 1'b1, got);
        chk("drain_empty", longint'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
